// File: rtl/pixel_proc.sv
// Two-stage RGB colour classifier: stage 1 extracts max/delta/dominant channel, stage 2 computes hue and class.
// Define PIXEL_PROC_CFG_PORT_EN to take the five hue windows from the classifier_config port instead of parameters.
module pixel_proc #(
    parameter int unsigned VAL_MIN = 64,
    parameter int unsigned SAT_MIN = 96,
    parameter int unsigned RED_LO  = 330,
    parameter int unsigned RED_HI  = 30,
    parameter int unsigned YEL_LO  = 50,
    parameter int unsigned YEL_HI  = 70,
    parameter int unsigned GRN_LO  = 90,
    parameter int unsigned GRN_HI  = 170,
    parameter int unsigned BLU_LO  = 200,
    parameter int unsigned BLU_HI  = 250,
    parameter int unsigned PNK_LO  = 270,
    parameter int unsigned PNK_HI  = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_in,
`ifdef PIXEL_PROC_CFG_PORT_EN
    input  logic [89:0] classifier_config,
`endif
    output logic [2:0]  pixel_classification
);

    typedef enum logic [1:0] {DOM_R, DOM_G, DOM_B} dom_e;

    localparam logic [7:0]  VAL_K = 8'(VAL_MIN);
    localparam logic [15:0] SAT_K = 16'(SAT_MIN);

    logic [7:0]        r_c, g_c, b_c, min_c;
    logic [7:0]        max_d, max_q, delta_d, delta_q;
    logic signed [8:0] diff_d, diff_q;
    dom_e              dom_d, dom_q;
    logic [2:0]        class_d, class_q;

    assign r_c = pixel_in[23:16];
    assign g_c = pixel_in[15:8];
    assign b_c = pixel_in[7:0];

    // Stage 1: ties resolve R > G > B; diff is the numerator of the hue term
    always_comb begin
        dom_d  = DOM_R;
        max_d  = r_c;
        diff_d = $signed({1'b0, g_c}) - $signed({1'b0, b_c});
        if (r_c >= g_c && r_c >= b_c) begin
            dom_d  = DOM_R;
            max_d  = r_c;
            diff_d = $signed({1'b0, g_c}) - $signed({1'b0, b_c});
        end else if (g_c >= b_c) begin
            dom_d  = DOM_G;
            max_d  = g_c;
            diff_d = $signed({1'b0, b_c}) - $signed({1'b0, r_c});
        end else begin
            dom_d  = DOM_B;
            max_d  = b_c;
            diff_d = $signed({1'b0, r_c}) - $signed({1'b0, g_c});
        end
        if (r_c <= g_c && r_c <= b_c)
            min_c = r_c;
        else if (g_c <= b_c)
            min_c = g_c;
        else
            min_c = b_c;
        delta_d = max_d - min_c;
    end

    logic [8:0] lo_w [5];
    logic [8:0] hi_w [5];

    always_comb begin
`ifdef PIXEL_PROC_CFG_PORT_EN
        for (int k = 0; k < 5; k++) begin
            lo_w[k] = classifier_config[89 - 18*k -: 9];
            hi_w[k] = classifier_config[80 - 18*k -: 9];
        end
`else
        lo_w[0] = 9'(RED_LO);  hi_w[0] = 9'(RED_HI);
        lo_w[1] = 9'(YEL_LO);  hi_w[1] = 9'(YEL_HI);
        lo_w[2] = 9'(GRN_LO);  hi_w[2] = 9'(GRN_HI);
        lo_w[3] = 9'(BLU_LO);  hi_w[3] = 9'(BLU_HI);
        lo_w[4] = 9'(PNK_LO);  hi_w[4] = 9'(PNK_HI);
`endif
    end

    function automatic logic in_win(input logic [15:0] h, input logic [8:0] lo, input logic [8:0] hi);
        logic [15:0] lo16, hi16;
        lo16 = {7'd0, lo};
        hi16 = {7'd0, hi};
        if (lo <= hi)
            return (h >= lo16) && (h <= hi16);
        else
            return (h >= lo16) || (h <= hi16);
    endfunction

    logic signed [15:0] dext, num, den, quo, base, h_s;
    logic [15:0]        hue, sat_lhs, sat_rhs;

    // Stage 2: signed division truncates toward zero, matching the hue definition
    always_comb begin
        dext = {{7{diff_q[8]}}, diff_q};
        num  = dext * 16'sd60;
        den  = (delta_q == 8'd0) ? 16'sd1 : $signed({8'd0, delta_q});
        quo  = num / den;
        case (dom_q)
            DOM_G:   base = 16'sd120;
            DOM_B:   base = 16'sd240;
            default: base = 16'sd0;
        endcase
        h_s = quo + base;
        if (h_s < 16'sd0)
            h_s = h_s + 16'sd360;
        if (h_s >= 16'sd360)
            h_s = h_s - 16'sd360;
        hue = (delta_q == 8'd0) ? 16'd0 : $unsigned(h_s);

        sat_lhs = {8'd0, delta_q} * 16'd255;
        sat_rhs = {8'd0, max_q} * SAT_K;

        class_d = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (in_win(hue, lo_w[k], hi_w[k]))
                class_d = 3'(k + 1);
        end
        if (delta_q == 8'd0 || max_q < VAL_K || sat_lhs < sat_rhs)
            class_d = 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q   <= '0;
            delta_q <= '0;
            diff_q  <= '0;
            dom_q   <= DOM_R;
            class_q <= '0;
        end else begin
            max_q   <= max_d;
            delta_q <= delta_d;
            diff_q  <= diff_d;
            dom_q   <= dom_d;
            class_q <= class_d;
        end
    end

    assign pixel_classification = class_q;

endmodule

// File: tb/tb_pixel_proc.sv
// Scoreboard bench for pixel_proc: driver queues expected classes, monitor checks them 2 edges later.
module tb_pixel_proc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pixel_in = '0;
    logic [2:0]  pixel_classification;
`ifdef PIXEL_PROC_CFG_PORT_EN
    logic [89:0] classifier_config = '0;
`endif

    pixel_proc dut (
        .clk                  (clk),
        .rst                  (rst),
        .pixel_in             (pixel_in),
`ifdef PIXEL_PROC_CFG_PORT_EN
        .classifier_config    (classifier_config),
`endif
        .pixel_classification (pixel_classification)
    );

    always #5 clk = ~clk;

    typedef struct {int exp; int due; int id;} sb_t;
    sb_t sb[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  next_id = 0;
    int  wlo[5];
    int  whi[5];

    always @(posedge clk) begin
        sb_t e;
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (pixel_classification !== 3'(e.exp)) begin
                bad++;
                $display("FAIL out#%0d got=%0d want=%0d", e.id, pixel_classification, e.exp);
            end
        end
    end

    function automatic int ref_class(input logic [23:0] p);
        int r, g, b, mx, mn, d, hue;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        d  = mx - mn;
        if (d == 0 || mx < 64 || d * 255 < 96 * mx)
            return 0;
        if (r >= g && r >= b) begin
            hue = (60 * (g - b)) / d;
            if (hue < 0) hue = hue + 360;
        end else if (g >= b)
            hue = 120 + (60 * (b - r)) / d;
        else
            hue = 240 + (60 * (r - g)) / d;
        if (hue == 360) hue = 0;
        for (int k = 0; k < 5; k++) begin
            if (wlo[k] <= whi[k]) begin
                if (hue >= wlo[k] && hue <= whi[k]) return k + 1;
            end else begin
                if (hue >= wlo[k] || hue <= whi[k]) return k + 1;
            end
        end
        return 0;
    endfunction

    task automatic drive(input logic [23:0] pix, input logic r, input int exp);
        @(negedge clk);
        rst = r;
        pixel_in = pix;
        sb.push_back('{exp, cyc + 2, next_id});
        next_id++;
    endtask

`ifdef PIXEL_PROC_CFG_PORT_EN
    task automatic load_cfg();
        for (int k = 0; k < 5; k++) begin
            classifier_config[89 - 18*k -: 9] = 9'(wlo[k]);
            classifier_config[80 - 18*k -: 9] = 9'(whi[k]);
        end
    endtask
`endif

    logic [23:0] vec_pix [16] = '{
        24'hff0000, 24'hffff00, 24'h00ff00, 24'h0000ff, 24'hff00ff,
        24'h808080, 24'h300000, 24'hffc0c0, 24'hff0080, 24'hff8000,
        24'hff9900, 24'h00ffff, 24'h00ff80, 24'h000000, 24'hffffff, 24'hffff00};
    int vec_exp [16] = '{1, 2, 3, 4, 5, 0, 0, 0, 1, 1, 0, 0, 3, 0, 0, 2};

    initial begin
        logic [23:0] p;
        int          waited;
        wlo = '{330, 50, 90, 200, 270};
        whi = '{30, 70, 170, 250, 320};
`ifdef PIXEL_PROC_CFG_PORT_EN
        load_cfg();
`endif
        drive(24'hff0000, 1'b1, 0);
        #1;
        total++;
        if (pixel_classification !== 3'd0) begin
            bad++;
            $display("FAIL reset_out got=%0d want=0", pixel_classification);
        end
        drive(24'h00ff00, 1'b1, 0);
        drive(24'hff0000, 1'b0, 1);

        foreach (vec_pix[i])
            drive(vec_pix[i], 1'b0, vec_exp[i]);

        for (int i = 0; i < 100; i++) begin
            p = 24'hff0000 | 24'($urandom_range(0, 16'hffff));
            if (i == 50) begin
                @(negedge clk);
                rst = 1'b1;
                pixel_in = p;
                sb.push_back('{0, cyc + 2, next_id});
                next_id++;
                #1;
                total++;
                if (pixel_classification !== 3'd0) begin
                    bad++;
                    $display("FAIL midreset_out got=%0d want=0", pixel_classification);
                end
                foreach (sb[j]) sb[j].exp = 0;
                drive(24'hff0000, 1'b1, 0);
                drive(24'h0000ff, 1'b1, 0);
            end else begin
                drive(p, 1'b0, ref_class(p));
            end
        end

`ifdef PIXEL_PROC_CFG_PORT_EN
        repeat (3) drive(24'h000000, 1'b0, 0);
        wlo[2] = 100;
        whi[2] = 140;
        load_cfg();
        drive(24'h00ff00, 1'b0, 3);
        drive(24'h00ff80, 1'b0, 0);
        drive(24'hff0000, 1'b0, 1);
`endif

        drive(24'h000000, 1'b0, 0);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
